// File: rtl/adder_pipe_feeder_if.sv
// Signal bundle joining the multiplier, the feeder, adder_pipe and the row-sum consumer.
// The feeder takes the slave view; the surrounding fabric (or a bench) takes the master view.
interface adder_pipe_feeder_if #(
  parameter int ROW_WIDTH = 10
);
  logic                 push_in;
  logic [ROW_WIDTH-1:0] row_in;
  logic [65:0]          v_in;
  logic                 flush_in;
  logic                 ready_out;
  logic                 add_push;
  logic [ROW_WIDTH-1:0] add_row;
  logic [65:0]          add_v0;
  logic [65:0]          add_v1;
  logic                 fb_push;
  logic [ROW_WIDTH-1:0] fb_row;
  logic [65:0]          fb_v;
  logic                 done_push;
  logic [ROW_WIDTH-1:0] done_row;
  logic [65:0]          done_v;

  modport slave (
    input  push_in, row_in, v_in, flush_in, fb_push, fb_row, fb_v,
    output ready_out, add_push, add_row, add_v0, add_v1, done_push, done_row, done_v
  );

  modport master (
    output push_in, row_in, v_in, flush_in, fb_push, fb_row, fb_v,
    input  ready_out, add_push, add_row, add_v0, add_v1, done_push, done_row, done_v
  );
endinterface

// File: rtl/adder_pipe_feeder.sv
// Issue side of the MAC reduction loop: pairs same-row products and adder feedback into
// adder_pipe until one value per row remains, then emits it as the finished row sum.
module adder_pipe_feeder #(
  parameter int ROW_WIDTH   = 10,
  parameter int ADD_LATENCY = 11,
  parameter int CNT_WIDTH   = 5
) (
  input  logic               clk,
  input  logic               rst,
  adder_pipe_feeder_if.slave bus
);
  localparam int VW = 66;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic                 slot_v, slot_v_d;
  logic [VW-1:0]        slot_val, slot_val_d;
  logic                 next_v, next_v_d;
  logic [ROW_WIDTH-1:0] next_row, next_row_d;
  logic [VW-1:0]        next_val, next_val_d;
  logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
  logic                 ready_q, ready_d;

  logic                 add_push_q;
  logic [ROW_WIDTH-1:0] add_row_q;
  logic [VW-1:0]        add_v0_q, add_v1_q;
  logic                 done_push_q, done_push_d;
  logic [ROW_WIDTH-1:0] done_row_q, done_row_d;
  logic [VW-1:0]        done_v_q, done_v_d;

  logic                 accept, fb_ok, use_i, use_f, drained;
  logic                 issue;
  logic [VW-1:0]        issue_v0, issue_v1;

  // Feedback seen in IDLE belongs to a row discarded by reset and is ignored.
  assign accept  = bus.push_in && ready_q;
  assign fb_ok   = bus.fb_push && (state_q != S_IDLE);
  assign use_i   = accept && (state_q == S_ACCUM) && (bus.row_in == row_q);
  assign use_f   = fb_ok;
  assign drained = (state_q == S_DRAIN) && (inflight_q == '0) && !bus.fb_push;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    slot_v_d    = slot_v;
    slot_val_d  = slot_val;
    next_v_d    = next_v;
    next_row_d  = next_row;
    next_val_d  = next_val;
    done_push_d = 1'b0;
    done_row_d  = done_row_q;
    done_v_d    = done_v_q;
    issue       = 1'b0;
    issue_v0    = slot_val;
    issue_v1    = bus.v_in;

    // Pairing: input with feedback leaves the slot alone; a lone source pairs with the slot or fills it.
    if (use_i && use_f) begin
      issue    = 1'b1;
      issue_v0 = bus.v_in;
      issue_v1 = bus.fb_v;
    end else if (use_i || use_f) begin
      if (slot_v) begin
        issue    = 1'b1;
        issue_v0 = slot_val;
        issue_v1 = use_i ? bus.v_in : bus.fb_v;
        slot_v_d = 1'b0;
      end else begin
        slot_v_d   = 1'b1;
        slot_val_d = use_i ? bus.v_in : bus.fb_v;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_ACCUM;
          row_d      = bus.row_in;
          slot_v_d   = 1'b1;
          slot_val_d = bus.v_in;
        end
      end
      S_ACCUM: begin
        if (accept && (bus.row_in != row_q)) begin
          // First product of the following row waits in the skid while this row drains.
          next_v_d   = 1'b1;
          next_row_d = bus.row_in;
          next_val_d = bus.v_in;
          state_d    = S_DRAIN;
        end else if (bus.flush_in && !bus.push_in) begin
          next_v_d = 1'b0;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          if (slot_v) begin
            done_push_d = 1'b1;
            done_row_d  = row_q;
            done_v_d    = slot_val;
          end
          if (next_v) begin
            row_d      = next_row;
            slot_v_d   = 1'b1;
            slot_val_d = next_val;
            next_v_d   = 1'b0;
            state_d    = S_ACCUM;
          end else begin
            slot_v_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inflight_d = inflight_q + CNT_WIDTH'(issue) - CNT_WIDTH'(fb_ok);
  assign ready_d    = (state_d != S_DRAIN);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      slot_v      <= 1'b0;
      slot_val    <= '0;
      next_v      <= 1'b0;
      next_row    <= '0;
      next_val    <= '0;
      inflight_q  <= '0;
      ready_q     <= 1'b1;
      add_push_q  <= 1'b0;
      add_row_q   <= '0;
      add_v0_q    <= '0;
      add_v1_q    <= '0;
      done_push_q <= 1'b0;
      done_row_q  <= '0;
      done_v_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      slot_v      <= slot_v_d;
      slot_val    <= slot_val_d;
      next_v      <= next_v_d;
      next_row    <= next_row_d;
      next_val    <= next_val_d;
      inflight_q  <= inflight_d;
      ready_q     <= ready_d;
      add_push_q  <= issue;
      add_row_q   <= row_q;
      if (issue) begin
        add_v0_q <= issue_v0;
        add_v1_q <= issue_v1;
      end
      done_push_q <= done_push_d;
      done_row_q  <= done_row_d;
      done_v_q    <= done_v_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.add_push  = add_push_q;
  assign bus.add_row   = add_row_q;
  assign bus.add_v0    = add_v0_q;
  assign bus.add_v1    = add_v1_q;
  assign bus.done_push = done_push_q;
  assign bus.done_row  = done_row_q;
  assign bus.done_v    = done_v_q;

  a_flush_with_push: assert property (@(posedge clk) disable iff (rst)
    !(bus.flush_in && bus.push_in));
  a_push_when_stalled: assert property (@(posedge clk) disable iff (rst)
    bus.push_in |-> ready_q);
  a_single_issue: assert property (@(posedge clk) disable iff (rst)
    $onehot0({use_i && use_f, slot_v && (use_i ^ use_f)}));
  // Counted from the issue decision through the feedback cycle: one cycle longer than the pipe.
  a_inflight_max: assert property (@(posedge clk) disable iff (rst)
    inflight_q <= CNT_WIDTH'(ADD_LATENCY + 1));
  a_inflight_underflow: assert property (@(posedge clk) disable iff (rst)
    fb_ok |-> (inflight_q != '0));
  a_fb_row: assert property (@(posedge clk) disable iff (rst)
    fb_ok |-> (bus.fb_row == row_q));
endmodule
